// File: rtl/scpad_types_pkg.sv
// Shared scratchpad scheduler types: command descriptor and backend arbiter FSM states.
package scpad_types_pkg;

    localparam int SCPAD_ID_WIDTH       = 2;
    localparam int SPAD_ROW_ADDR_WIDTH  = 10;
    localparam int DRAM_ADDR_WIDTH      = 32;
    localparam int ROW_FIELD_W          = 5;

    // spad_addr carries the scratchpad id in its top bits
    typedef struct packed {
        logic                                          write;
        logic                                          row_or_col;
        logic [SCPAD_ID_WIDTH+SPAD_ROW_ADDR_WIDTH-1:0] spad_addr;
        logic [DRAM_ADDR_WIDTH-1:0]                    dram_addr;
        logic [ROW_FIELD_W-1:0]                        num_rows;
        logic [ROW_FIELD_W-1:0]                        num_cols;
    } sched_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/be_sched_arb_if.sv
// Requester and backend signals of the scheduler-to-scratchpad backend arbiter.
interface be_sched_arb_if import scpad_types_pkg::*; #(
    parameter int NREQ = 2
) ();
    localparam int OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]              req_valid;
    sched_req_t [NREQ-1:0]        req_cmd;
    logic [NREQ-1:0]              req_ready;
    logic                         be_cmd_valid;
    sched_req_t                   be_cmd;
    logic                         be_cmd_ready;
    logic                         be_row_done;
    logic [NREQ-1:0]              res_valid;
    logic                         busy;
    logic [OWN_W-1:0]             owner;
    logic                         spurious_done;

    modport master (
        output req_valid, req_cmd, be_cmd_ready, be_row_done,
        input  req_ready, be_cmd_valid, be_cmd, res_valid, busy, owner, spurious_done
    );

    modport slave (
        input  req_valid, req_cmd, be_cmd_ready, be_row_done,
        output req_ready, be_cmd_valid, be_cmd, res_valid, busy, owner, spurious_done
    );
endinterface

// File: rtl/scpad_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins, one-hot grant.
module scpad_rr_arb #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);
    logic w_found;

    // d is the distance from ptr; the smallest distance with a request wins
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int d = 0; d < NREQ; d++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && req[j] && (((j - int'(ptr) + NREQ) % NREQ) == d)) begin
                    grant[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/be_sched_arb.sv
// Shares one scratchpad backend between NREQ schedulers: grant, issue, count rows, respond.
//   state | meaning
//   IDLE  | waiting for a request; grants round-robin
//   ISSUE | be_cmd_valid high until backend handshake
//   RUN   | counting be_row_done pulses up to num_rows
//   RESP  | one-cycle res_valid to owner, no grant
module be_sched_arb import scpad_types_pkg::*; #(
    parameter int NREQ  = 2,
    parameter int ROW_W = 5
) (
    input  logic           clk,
    input  logic           n_rst,
    be_sched_arb_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e     r_state, w_state_nxt;
    logic [PW-1:0]    r_rr_ptr, r_owner;
    logic [ROW_W-1:0] r_row_cnt, w_row_nxt;
    sched_req_t       r_cmd;
    logic             r_spurious;

    logic [NREQ-1:0]  w_grant, w_req_ready, w_res;
    logic [PW-1:0]    w_g_idx, w_ptr_nxt;
    logic             w_grant_en, w_spur_set, w_cmd_valid, w_last_row;

    scpad_rr_arb #(.NREQ(NREQ), .PW(PW)) u_rr_arb (
        .req   (bus.req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_g_idx   = '0;
        w_ptr_nxt = r_rr_ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant[j]) begin
                w_g_idx   = PW'(j);
                w_ptr_nxt = PW'((j + 1) % NREQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_cnt;
        w_grant_en  = 1'b0;
        w_spur_set  = 1'b0;
        w_req_ready = '0;
        w_cmd_valid = 1'b0;
        w_last_row  = (r_row_cnt == ROW_W'(r_cmd.num_rows));
        unique case (r_state)
            IDLE: begin
                w_spur_set = bus.be_row_done;
                // n_rst gate keeps req_ready low while reset is held
                if (|bus.req_valid && n_rst) begin
                    w_grant_en  = 1'b1;
                    w_req_ready = w_grant;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_cmd_valid = 1'b1;
                if (bus.be_cmd_ready) begin
                    w_row_nxt   = '0;
                    w_state_nxt = RUN;
                    if (bus.be_row_done) begin
                        if (r_cmd.num_rows == '0) w_state_nxt = RESP;
                        else                      w_row_nxt   = ROW_W'(1);
                    end
                end
            end
            RUN: begin
                if (bus.be_row_done) begin
                    if (w_last_row) w_state_nxt = RESP;
                    else            w_row_nxt   = r_row_cnt + 1'b1;
                end
            end
            RESP: begin
                w_spur_set  = bus.be_row_done;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_row_cnt  <= '0;
            r_owner    <= '0;
            r_cmd      <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_cnt <= w_row_nxt;
            if (w_grant_en) begin
                r_cmd    <= bus.req_cmd[w_g_idx];
                r_owner  <= w_g_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_spur_set) r_spurious <= 1'b1;
        end
    end

    always_comb begin
        w_res = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (r_state == RESP && r_owner == PW'(j)) w_res[j] = 1'b1;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.be_cmd_valid  = w_cmd_valid;
    assign bus.be_cmd        = r_cmd;
    assign bus.res_valid     = w_res;
    assign bus.busy          = (r_state != IDLE);
    assign bus.owner         = r_owner;
    assign bus.spurious_done = r_spurious;
endmodule

// File: tb/tb_be_sched_arb.sv
// Directed bench for be_sched_arb: cycle-accurate scenarios with hand-computed expectations.
module tb_be_sched_arb;
    import scpad_types_pkg::*;

    logic clk;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;

    be_sched_arb_if #(.NREQ(2)) bus ();

    be_sched_arb #(.NREQ(2), .ROW_W(5)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic sched_req_t mk(input logic [4:0] rows, input logic [31:0] tag);
        sched_req_t c;
        c.write      = tag[0];
        c.row_or_col = tag[1];
        c.spad_addr  = tag[11:0];
        c.dram_addr  = tag ^ 32'hA5A5_0000;
        c.num_rows   = rows;
        c.num_cols   = tag[8:4];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
        checks++; if (bus.be_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %b want 0", bus.be_cmd_valid); end
        checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL rst_res_valid: got %b want 00", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b want 0", bus.owner); end
        checks++; if (bus.be_cmd !== '0) begin errors++; $display("FAIL rst_be_cmd: got %h want 0", bus.be_cmd); end
        checks++; if (bus.spurious_done !== 1'b0) begin errors++; $display("FAIL rst_spurious: got %b want 0", bus.spurious_done); end
        bus.req_valid = 2'b00;
        n_rst = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        sched_req_t cmd_a;
        cmd_a = mk(5'd3, 32'h1234_5678);
        bus.req_cmd[0] = cmd_a;
        bus.req_valid  = 2'b01;
        settle();
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        settle();
        checks++; if (bus.be_cmd_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %b want 1", bus.be_cmd_valid); end
        checks++; if (bus.be_cmd !== cmd_a) begin errors++; $display("FAIL single_be_cmd: got %h want %h", bus.be_cmd, cmd_a); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_issue: got %b want 00", bus.req_ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.be_cmd_valid !== 1'b1) begin errors++; $display("FAIL single_issue2: got %b want 1", bus.be_cmd_valid); end
        bus.be_cmd_ready = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        settle();
        checks++; if (bus.be_cmd_valid !== 1'b0) begin errors++; $display("FAIL single_run_valid: got %b want 0", bus.be_cmd_valid); end
        for (int k = 0; k < 4; k++) begin
            bus.be_row_done = 1'b1;
            settle();
            checks++; if (bus.res_valid !== 2'b00 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_run_row%0d: res_valid %b busy %b want 00 1", k, bus.res_valid, bus.busy); end
            tick();
        end
        bus.be_row_done = 1'b0;
        settle();
        checks++; if (bus.res_valid !== 2'b01) begin errors++; $display("FAIL single_resp: got %b want 01", bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL single_resp_once: got %b want 00", bus.res_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
        checks++; if (bus.be_cmd !== cmd_a) begin errors++; $display("FAIL single_hold_cmd: got %h want %h", bus.be_cmd, cmd_a); end
    endtask

    task automatic test_contention();
        sched_req_t cmds [2];
        logic       exp_g;
        logic [1:0] exp_oh;
        n_rst = 1'b0;
        settle();
        n_rst = 1'b1;
        cmds[0] = mk(5'd0, 32'hAAAA_0000);
        cmds[1] = mk(5'd0, 32'h5555_0001);
        bus.req_cmd[0] = cmds[0];
        bus.req_cmd[1] = cmds[1];
        bus.req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 1);
            exp_oh = exp_g ? 2'b10 : 2'b01;
            settle();
            checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", k, bus.req_ready, exp_oh); end
            tick();
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL cont_pulse%0d: got %b want 00", k, bus.req_ready); end
            checks++; if (bus.owner !== exp_g) begin errors++; $display("FAIL cont_owner%0d: got %b want %b", k, bus.owner, exp_g); end
            checks++; if (bus.be_cmd !== cmds[exp_g]) begin errors++; $display("FAIL cont_cmd%0d: got %h want %h", k, bus.be_cmd, cmds[exp_g]); end
            bus.be_cmd_ready = 1'b1;
            tick();
            bus.be_cmd_ready = 1'b0;
            bus.be_row_done  = 1'b1;
            tick();
            bus.be_row_done  = 1'b0;
            settle();
            checks++; if (bus.res_valid !== exp_oh) begin errors++; $display("FAIL cont_resp%0d: got %b want %b", k, bus.res_valid, exp_oh); end
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL cont_no_grant_resp%0d: got %b want 00", k, bus.req_ready); end
            tick();
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        sched_req_t cmd_b;
        cmd_b = mk(5'd2, 32'hDEAD_BEEF);
        bus.req_cmd[1] = cmd_b;
        bus.req_valid  = 2'b10;
        settle();
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid  = 2'b00;
        bus.req_cmd[1] = mk(5'd7, 32'h0000_0000);
        for (int k = 0; k < 10; k++) begin
            settle();
            checks++; if (bus.be_cmd_valid !== 1'b1 || bus.be_cmd !== cmd_b) begin errors++; $display("FAIL bp_hold%0d: valid %b cmd %h want 1 %h", k, bus.be_cmd_valid, bus.be_cmd, cmd_b); end
            tick();
        end
        bus.be_cmd_ready = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        bus.be_row_done  = 1'b1;
        repeat (3) tick();
        bus.be_row_done  = 1'b0;
        settle();
        checks++; if (bus.res_valid !== 2'b10) begin errors++; $display("FAIL bp_resp: got %b want 10", bus.res_valid); end
        tick();
    endtask

    task automatic test_rows_boundary();
        bus.req_cmd[0] = mk(5'd0, 32'h0000_0F0F);
        bus.req_valid  = 2'b01;
        tick();
        bus.req_valid    = 2'b00;
        bus.be_cmd_ready = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        bus.be_row_done  = 1'b1;
        tick();
        bus.be_row_done  = 1'b0;
        settle();
        checks++; if (bus.res_valid !== 2'b01) begin errors++; $display("FAIL rows0_resp: got %b want 01", bus.res_valid); end
        tick();
        bus.req_cmd[0] = mk(5'd31, 32'h3131_3131);
        bus.req_valid  = 2'b01;
        tick();
        bus.req_valid    = 2'b00;
        bus.be_cmd_ready = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bus.be_row_done = 1'b1;
            settle();
            checks++; if (bus.res_valid !== 2'b00 || bus.busy !== 1'b1) begin errors++; $display("FAIL rows31_run%0d: res_valid %b busy %b want 00 1", k, bus.res_valid, bus.busy); end
            tick();
        end
        bus.be_row_done = 1'b0;
        settle();
        checks++; if (bus.res_valid !== 2'b01) begin errors++; $display("FAIL rows31_resp: got %b want 01", bus.res_valid); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rows31_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_coincident();
        bus.req_cmd[0] = mk(5'd0, 32'h0C0C_0C0C);
        bus.req_valid  = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        settle();
        checks++; if (bus.be_cmd_valid !== 1'b1) begin errors++; $display("FAIL coin_issue: got %b want 1", bus.be_cmd_valid); end
        bus.be_cmd_ready = 1'b1;
        bus.be_row_done  = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        bus.be_row_done  = 1'b0;
        settle();
        checks++; if (bus.res_valid !== 2'b01) begin errors++; $display("FAIL coin_resp: got %b want 01", bus.res_valid); end
        checks++; if (bus.spurious_done !== 1'b0) begin errors++; $display("FAIL coin_spurious: got %b want 0", bus.spurious_done); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coin_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_spurious_reset();
        bus.be_row_done = 1'b1;
        tick();
        bus.be_row_done = 1'b0;
        settle();
        checks++; if (bus.spurious_done !== 1'b1) begin errors++; $display("FAIL spur_set: got %b want 1", bus.spurious_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle: got %b want 0", bus.busy); end
        bus.req_cmd[0] = mk(5'd1, 32'h0101_0101);
        bus.req_valid  = 2'b01;
        tick();
        bus.req_valid    = 2'b00;
        bus.be_cmd_ready = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        bus.be_row_done  = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL spur_row1: got %b want 00", bus.res_valid); end
        tick();
        bus.be_row_done = 1'b0;
        settle();
        checks++; if (bus.res_valid !== 2'b01) begin errors++; $display("FAIL spur_row2_resp: got %b want 01", bus.res_valid); end
        tick();
        bus.req_cmd[0] = mk(5'd3, 32'h0404_0404);
        bus.req_valid  = 2'b01;
        tick();
        bus.req_valid    = 2'b00;
        bus.be_cmd_ready = 1'b1;
        tick();
        bus.be_cmd_ready = 1'b0;
        bus.be_row_done  = 1'b1;
        repeat (2) tick();
        bus.be_row_done = 1'b0;
        settle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", bus.busy); end
        n_rst = 1'b0;
        settle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", bus.busy); end
        checks++; if (bus.spurious_done !== 1'b0) begin errors++; $display("FAIL rst_async_spur: got %b want 0", bus.spurious_done); end
        checks++; if (bus.be_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.be_cmd_valid); end
        tick();
        checks++; if (bus.res_valid !== 2'b00) begin errors++; $display("FAIL rst_hold_res: got %b want 00", bus.res_valid); end
        n_rst = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_after: res_valid %b busy %b want 00 0", bus.res_valid, bus.busy); end
    endtask

    initial begin
        n_rst            = 1'b0;
        bus.req_valid    = 2'b11;
        bus.req_cmd[0]   = mk(5'd5, 32'hFFFF_0001);
        bus.req_cmd[1]   = mk(5'd6, 32'hFFFF_0002);
        bus.be_cmd_ready = 1'b0;
        bus.be_row_done  = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_rows_boundary();
        test_coincident();
        test_spurious_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
